add_sub_64_arbiter: RTL and testbench
=====================================

ADD_SUB_64_ARBITER -- requirements
Module: add_sub_64_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, meaning: number of requesters sharing one ADD_SUB_64 unit.
REQ-002 Parameter LATENCY, default 7, meaning: adder pipeline depth in clocks.
REQ-003 Port clk, input, 1, meaning: single clock; all logic SHALL be on its rising edge.
REQ-004 Port rst_control, input, 1, meaning: reset; SHALL be asynchronous and active-high.
REQ-005 Port req, input, NUM_REQ, meaning: per-requester operation request, held until granted.
REQ-006 Port req_add_sub, input, NUM_REQ, meaning: per-requester op select, 1=add, 0=sub.
REQ-007 Port req_dataa / req_datab, input, NUM_REQ*`EXTENDED_SINGLE each, meaning: flattened operands; slice i belongs to requester i.
REQ-008 Port gnt, output, NUM_REQ, meaning: one-hot grant, combinational, same cycle as winning req.
REQ-009 Port flush, input, 1, meaning: stop issuing and drain the adder.
REQ-010 Port adder_add_sub / adder_dataa / adder_datab, output, 1 / `EXTENDED_SINGLE / `EXTENDED_SINGLE, meaning: registered drive to ADD_SUB_64.
REQ-011 Port adder_result, input, `EXTENDED_SINGLE, meaning: ADD_SUB_64 result.
REQ-012 Port result, output, `EXTENDED_SINGLE, meaning: result broadcast to all requesters.
REQ-013 Port result_valid, output, NUM_REQ, meaning: one-hot single-cycle pulse marking the result owner.
REQ-014 Port flush_done, output, 1, meaning: single-cycle pulse when the drain completes.
REQ-015 Port arb_busy, output, 1, meaning: high when state is not IDLE or any op is in flight.

Function
REQ-016 Arbitration SHALL be round-robin: highest priority at rr_ptr, descending modulo NUM_REQ; after a grant to w, rr_ptr SHALL become (w+1) mod NUM_REQ; with no grant, rr_ptr SHALL hold.
REQ-017 At most one gnt bit SHALL be high per cycle; gnt SHALL be 0 when req=0, in DRAIN, or when flush=1.
REQ-018 When gnt[w] is high in cycle t, operands and add_sub of w SHALL be registered onto the adder ports at the end of t; a tag (valid, w) SHALL enter a LATENCY+1-deep shift register.
REQ-019 result_valid[w] SHALL pulse in cycle t+LATENCY+1 (t+8 by default); result SHALL equal adder_result in that cycle.
REQ-020 Back-to-back grants every cycle SHALL be supported: throughput 1 op/clock, no bubbles.
REQ-021 adder_* outputs SHALL hold their last value when no grant occurs.
REQ-022 State machine states: IDLE (no ops in flight, no req), RUN (issuing or ops in flight), DRAIN (flush accepted).
REQ-023 Transitions: IDLE->RUN on any req; RUN->IDLE when req=0 and tag pipe empty; IDLE/RUN->DRAIN on flush; DRAIN->IDLE when tag pipe empty, pulsing flush_done in the IDLE-entry cycle.
REQ-024 flush in IDLE with empty pipe SHALL pulse flush_done on the next cycle.
REQ-025 flush and req in the same cycle: flush SHALL win; no grant is issued.
REQ-026 Requests in DRAIN SHALL stay pending and be arbitrated after the return to IDLE.

Reset
REQ-027 On rst_control: state=IDLE, rr_ptr=0, tag pipe cleared, gnt=0, result_valid=0, flush_done=0, arb_busy=0, adder_*=0, result=0.
REQ-028 Reset mid-operation SHALL discard every in-flight tag; no result_valid SHALL pulse for them after reset release.

Configuration
REQ-029 Macro ADD_SUB_ARB_RESULT_REG_EN: when defined, result and result_valid SHALL pass through one extra register (latency t+LATENCY+2, tag pipe one stage deeper); when undefined, latency SHALL be t+LATENCY+1 as in REQ-019.

Structure
REQ-030 `EXTENDED_SINGLE, the default LATENCY value and the tag width SHALL live in the shared global_parameter.v include.
REQ-031 Round-robin grant logic SHALL be one sub-module, rr_arbiter (inputs req, rr_ptr; output one-hot gnt).

Verification
REQ-032 Single req[2]=1, dataa=1.5, datab=2.25, add: gnt=4'b0100 at t; result_valid=4'b0100 at t+8; result=3.75.
REQ-033 req=4'b1111 held for 8 cycles after reset: grants 0,1,2,3,0,1,2,3; result_valid follows the same order 8 cycles later.
REQ-034 req=4'b0001 streaming 5 ops at add_sub=0, 5.0-3.0: 5 consecutive result_valid[0] pulses, each 2.0.
REQ-035 Issue 3 ops, then flush next cycle with req=4'b0010: no grant; 3 results return; flush_done pulses once; grant to 1 afterwards.
REQ-036 Reset asserted 3 cycles after 2 grants: no result_valid afterwards; all outputs 0; rr_ptr=0.
REQ-037 With ADD_SUB_ARB_RESULT_REG_EN defined, REQ-032 stimulus: result_valid at t+9.

Source files
------------

// File: rtl/add_sub_64_arbiter_pkg.sv
// Shared types and global parameters for the ADD_SUB_64 arbiter.
// Holds the operand width (`EXTENDED_SINGLE), the default adder latency
// and the tag width. These are the values a global_parameter include would carry.
// Optional build macro: ADD_SUB_ARB_RESULT_REG_EN (used by the top).
`ifndef EXTENDED_SINGLE
`define EXTENDED_SINGLE 64
`endif

package add_sub_64_arbiter_pkg;

   localparam int EXT_W       = `EXTENDED_SINGLE;
   localparam int LATENCY_DEF = 7;
   localparam int TAG_W       = 8;   // requester index width carried with each op

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } arb_state_e;

   // One in-flight operation: valid bit plus the owning requester.
   typedef struct packed {
      logic             vld;
      logic [TAG_W-1:0] idx;
   } tag_t;

endpackage

// File: rtl/add_sub_64_arbiter_rr_arbiter.sv
// Round-robin grant: priority starts at rr_ptr and wraps upward modulo NUM_REQ.
// Pure combinational, one-hot (or zero) output.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int PTR_W   = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   rr_ptr,
   output logic [NUM_REQ-1:0] gnt
);

   logic [PTR_W-1:0] idx;

   // Walk from lowest to highest priority so the last hit (closest to rr_ptr) wins.
   always_comb begin
      gnt = '0;
      idx = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
         if (req[idx]) begin
            gnt      = '0;
            gnt[idx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/add_sub_64_arbiter.sv
// Shares one pipelined ADD_SUB_64 unit between NUM_REQ requesters.
// Round-robin issue, tag pipe tracks ownership, flush drains the adder.
// Optional macro ADD_SUB_ARB_RESULT_REG_EN adds an output register stage
// on result/result_valid (one extra cycle of latency).
module add_sub_64_arbiter
   import add_sub_64_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int LATENCY = LATENCY_DEF
) (
   input  logic                                clk,
   input  logic                                rst_control,
   input  logic [NUM_REQ-1:0]                  req,
   input  logic [NUM_REQ-1:0]                  req_add_sub,
   input  logic [NUM_REQ*`EXTENDED_SINGLE-1:0] req_dataa,
   input  logic [NUM_REQ*`EXTENDED_SINGLE-1:0] req_datab,
   output logic [NUM_REQ-1:0]                  gnt,
   input  logic                                flush,
   output logic                                adder_add_sub,
   output logic [`EXTENDED_SINGLE-1:0]         adder_dataa,
   output logic [`EXTENDED_SINGLE-1:0]         adder_datab,
   input  logic [`EXTENDED_SINGLE-1:0]         adder_result,
   output logic [`EXTENDED_SINGLE-1:0]         result,
   output logic [NUM_REQ-1:0]                  result_valid,
   output logic                                flush_done,
   output logic                                arb_busy
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
`ifdef ADD_SUB_ARB_RESULT_REG_EN
   localparam int DEPTH = LATENCY + 2;
`else
   localparam int DEPTH = LATENCY + 1;
`endif

   arb_state_e          state, state_nxt;
   logic [PTR_W-1:0]    rr_ptr, gnt_idx;
   logic [NUM_REQ-1:0]  req_ok;
   logic                issue_ok, any_gnt, pipe_empty;
   tag_t [DEPTH-1:0]    tag_pipe;
   tag_t                new_tag, out_tag;

   // Issue is blocked while draining, when flush is asserted, and during reset.
   assign issue_ok = (state != ST_DRAIN) && !flush && !rst_control;
   assign req_ok   = issue_ok ? req : '0;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_rr (
      .req    (req_ok),
      .rr_ptr (rr_ptr),
      .gnt    (gnt)
   );

   // Encode the one-hot grant into the winner index.
   always_comb begin
      gnt_idx = '0;
      for (int i = 0; i < NUM_REQ; i++)
         if (gnt[i]) gnt_idx = PTR_W'(i);
   end

   assign any_gnt     = |gnt;
   assign new_tag.vld = any_gnt;
   assign new_tag.idx = TAG_W'(gnt_idx);
   assign out_tag     = tag_pipe[DEPTH-1];

   // Pipe is empty when no stage (including any output stage) holds a live tag.
   always_comb begin
      pipe_empty = 1'b1;
      for (int k = 0; k < DEPTH; k++)
         if (tag_pipe[k].vld) pipe_empty = 1'b0;
   end

   // Next-state logic: flush always wins over new requests.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (flush)       state_nxt = ST_DRAIN;
            else if (|req)   state_nxt = ST_RUN;
         end
         ST_RUN: begin
            if (flush)                     state_nxt = ST_DRAIN;
            else if (!(|req) && pipe_empty) state_nxt = ST_IDLE;
         end
         ST_DRAIN: begin
            if (pipe_empty)  state_nxt = ST_IDLE;
         end
         default:            state_nxt = ST_IDLE;
      endcase
   end

   // Drain completes in the cycle the DRAIN state sees an empty pipe.
   assign flush_done = (state == ST_DRAIN) && pipe_empty;
   assign arb_busy   = (state != ST_IDLE) || !pipe_empty;

   // State register.
   always_ff @(posedge clk or posedge rst_control) begin
      if (rst_control) state <= ST_IDLE;
      else             state <= state_nxt;
   end

   // Pointer moves past the winner; it holds when nothing is granted.
   always_ff @(posedge clk or posedge rst_control) begin
      if (rst_control)  rr_ptr <= '0;
      else if (any_gnt) rr_ptr <= (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
   end

   // Ownership tags march alongside the adder pipeline; reset discards them all.
   always_ff @(posedge clk or posedge rst_control) begin
      if (rst_control) tag_pipe <= '0;
      else             tag_pipe <= {tag_pipe[DEPTH-2:0], new_tag};
   end

   // Register the winner's operands onto the adder; hold them otherwise.
   always_ff @(posedge clk or posedge rst_control) begin
      if (rst_control) begin
         adder_add_sub <= 1'b0;
         adder_dataa   <= '0;
         adder_datab   <= '0;
      end else if (any_gnt) begin
         adder_add_sub <= req_add_sub[gnt_idx];
         adder_dataa   <= req_dataa[gnt_idx*EXT_W +: EXT_W];
         adder_datab   <= req_datab[gnt_idx*EXT_W +: EXT_W];
      end
   end

   // Owner pulse decoded from the last tag stage.
   always_comb begin
      result_valid = '0;
      for (int i = 0; i < NUM_REQ; i++)
         result_valid[i] = out_tag.vld && (out_tag.idx == TAG_W'(i));
   end

`ifdef ADD_SUB_ARB_RESULT_REG_EN
   logic [EXT_W-1:0] result_q;

   // Capture the adder output when its tag reaches the adder-latency stage.
   always_ff @(posedge clk or posedge rst_control) begin
      if (rst_control) result_q <= '0;
      else             result_q <= tag_pipe[LATENCY].vld ? adder_result : '0;
   end

   assign result = result_q;
`else
   // Result is zero outside owner pulses so idle cycles show a clean bus.
   assign result = out_tag.vld ? adder_result : '0;
`endif

endmodule

// File: tb/tb_add_sub_64_arbiter.sv
// Self-checking bench for add_sub_64_arbiter: directed scenarios plus a
// randomized phase, checked against a cycle-level scoreboard model.
module tb_add_sub_64_arbiter;

   localparam int N   = 4;
   localparam int LAT = 7;
   localparam int W   = `EXTENDED_SINGLE;
`ifdef ADD_SUB_ARB_RESULT_REG_EN
   localparam int D = LAT + 2;
`else
   localparam int D = LAT + 1;
`endif

   logic           clk = 1'b0;
   logic           rst_control;
   logic [N-1:0]   req, req_add_sub, gnt, result_valid;
   logic [N*W-1:0] req_dataa, req_datab;
   logic           flush, adder_add_sub, flush_done, arb_busy;
   logic [W-1:0]   adder_dataa, adder_datab, adder_result, result;

   add_sub_64_arbiter #(.NUM_REQ(N), .LATENCY(LAT)) dut (
      .clk           (clk),
      .rst_control   (rst_control),
      .req           (req),
      .req_add_sub   (req_add_sub),
      .req_dataa     (req_dataa),
      .req_datab     (req_datab),
      .gnt           (gnt),
      .flush         (flush),
      .adder_add_sub (adder_add_sub),
      .adder_dataa   (adder_dataa),
      .adder_datab   (adder_datab),
      .adder_result  (adder_result),
      .result        (result),
      .result_valid  (result_valid),
      .flush_done    (flush_done),
      .arb_busy      (arb_busy)
   );

   always #5 clk = ~clk;

   // Behavioural ADD_SUB_64: double-precision add/sub, LAT clocks deep.
   logic [W-1:0] apipe [LAT] = '{default: '0};
   always @(posedge clk) begin
      for (int k = LAT - 1; k > 0; k--) apipe[k] <= apipe[k-1];
      apipe[0] <= $realtobits(adder_add_sub ?
                  ($bitstoreal(adder_dataa) + $bitstoreal(adder_datab)) :
                  ($bitstoreal(adder_dataa) - $bitstoreal(adder_datab)));
   end
   assign adder_result = apipe[LAT-1];

   // Requester-side operand storage.
   real op_a [N];
   real op_b [N];
   bit  op_add [N];

   // Scoreboard entry: owner, expected result bits, cycle it must appear.
   typedef struct {
      int           owner;
      logic [W-1:0] val;
      int           due;
   } exp_t;
   exp_t sb [$];

   int           errors = 0, checks = 0;
   int           cyc = 0, rr = 0, mode = 0;   // mode: 0 idle, 1 run, 2 drain
   logic         exp_as = 1'b0;
   logic [W-1:0] exp_a = '0, exp_b = '0;
   logic [N-1:0] g;

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic real rnd();
      return real'($urandom_range(0, 4000000)) / 256.0 - 7812.5;
   endfunction

   task automatic apply();
      for (int i = 0; i < N; i++) begin
         req_dataa[i*W +: W] = $realtobits(op_a[i]);
         req_datab[i*W +: W] = $realtobits(op_b[i]);
         req_add_sub = op_add[i] ? (req_add_sub | (N'(1) << i)) : (req_add_sub & ~(N'(1) << i));
      end
   endtask

   // One clock: called at posedge+1 with inputs applied; checks, updates model.
   task automatic step(output logic [N-1:0] eg);
      logic [N-1:0] erv;
      logic [W-1:0] eres;
      int pend, w;
      apply();
      #1;
      pend = sb.size();
      eg = '0; w = -1;
      if (mode != 2 && !flush && req != '0)
         for (int k = 0; k < N; k++)
            if (w < 0 && ((req >> ((rr + k) % N)) & N'(1)) != '0) w = (rr + k) % N;
      if (w >= 0) eg = N'(1) << w;
      erv = '0; eres = '0;
      if (sb.size() > 0 && sb[0].due == cyc) begin
         erv  = N'(1) << sb[0].owner;
         eres = sb[0].val;
         sb.delete(0);
      end
      check("gnt",           W'(gnt),           W'(eg));
      check("result_valid",  W'(result_valid),  W'(erv));
      check("result",        result,            eres);
      check("flush_done",    W'(flush_done),    W'(mode == 2 && pend == 0));
      check("arb_busy",      W'(arb_busy),      W'(mode != 0 || pend > 0));
      check("adder_add_sub", W'(adder_add_sub), W'(exp_as));
      check("adder_dataa",   adder_dataa,       exp_a);
      check("adder_datab",   adder_datab,       exp_b);
      if (w >= 0) begin
         exp_as = op_add[w];
         exp_a  = $realtobits(op_a[w]);
         exp_b  = $realtobits(op_b[w]);
         sb.push_back('{w, $realtobits(op_add[w] ? op_a[w] + op_b[w] : op_a[w] - op_b[w]), cyc + D});
         rr = (w + 1) % N;
      end
      case (mode)
         0: if (flush) mode = 2; else if (req != '0) mode = 1;
         1: if (flush) mode = 2; else if (req == '0 && pend == 0) mode = 0;
         default: if (pend == 0) mode = 0;
      endcase
      @(posedge clk); #1;
      cyc++;
   endtask

   task automatic idle(input int n);
      logic [N-1:0] t;
      req = '0; flush = 1'b0;
      repeat (n) step(t);
   endtask

   // Asynchronous reset, checked while asserted; model forgets everything.
   task automatic do_reset();
      req = '0; flush = 1'b0; rst_control = 1'b1;
      #1;
      check("rst_gnt",          W'(gnt),           '0);
      check("rst_result_valid", W'(result_valid),  '0);
      check("rst_flush_done",   W'(flush_done),    '0);
      check("rst_arb_busy",     W'(arb_busy),      '0);
      check("rst_adder_add_sub", W'(adder_add_sub), '0);
      check("rst_adder_dataa",  adder_dataa,       '0);
      check("rst_adder_datab",  adder_datab,       '0);
      check("rst_result",       result,            '0);
      sb.delete(); mode = 0; rr = 0;
      exp_as = 1'b0; exp_a = '0; exp_b = '0;
      repeat (2) @(posedge clk);
      #1;
      rst_control = 1'b0;
      cyc += 2;
   endtask

   initial begin
      req = '0; req_add_sub = '0; req_dataa = '0; req_datab = '0; flush = 1'b0;
      for (int i = 0; i < N; i++) begin op_a[i] = 0.0; op_b[i] = 0.0; op_add[i] = 1'b1; end
      do_reset();

      // Single add from requester 2: 1.5 + 2.25 = 3.75.
      op_a[2] = 1.5; op_b[2] = 2.25; op_add[2] = 1'b1;
      req = 4'b0100; step(g);
      idle(12);

      // All four requesting for 8 cycles: strict rotation.
      for (int i = 0; i < N; i++) begin op_a[i] = rnd(); op_b[i] = rnd(); op_add[i] = 1'(i % 2); end
      req = 4'b1111;
      repeat (8) step(g);
      idle(12);

      // Streaming subtracts from requester 0: five results of 2.0.
      op_a[0] = 5.0; op_b[0] = 3.0; op_add[0] = 1'b0;
      req = 4'b0001;
      repeat (5) step(g);
      idle(12);

      // Three ops, then flush with a pending request from 1.
      op_add[0] = 1'b1; op_add[1] = 1'b0; op_a[1] = 10.0; op_b[1] = 0.5;
      req = 4'b0001;
      repeat (3) step(g);
      flush = 1'b1; req = 4'b0010; step(g);
      flush = 1'b0;
      for (int k = 0; k < 15; k++) begin step(g); req &= ~g; end
      idle(12);

      // Flush from IDLE with nothing in flight.
      flush = 1'b1; step(g);
      idle(4);

      // Randomized traffic: requests held until granted, occasional flush.
      for (int c = 0; c < 300; c++) begin
         for (int i = 0; i < N; i++)
            if (((req >> i) & N'(1)) == '0 && $urandom_range(0, 2) == 0) begin
               op_a[i] = rnd(); op_b[i] = rnd(); op_add[i] = 1'($urandom_range(0, 1));
               req |= N'(1) << i;
            end
         flush = ($urandom_range(0, 24) == 0);
         step(g);
         req &= ~g;
      end
      idle(14);

      // Reset three cycles after two grants: in-flight ops vanish, pointer back to 0.
      req = 4'b0110;
      repeat (2) step(g);
      idle(3);
      do_reset();
      idle(12);
      req = 4'b1111; step(g);
      idle(12);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
